// File: rtl/uart_program_loader_if.sv
// Converter word stream and instruction-memory write port seen by the program loader.
// master: loader side; slave: converter/memory side.
interface uart_program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
) ();
  logic [31:0]           word_in;
  logic                  word_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;

  modport master (
    input  word_in, word_valid, mem_ack,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output word_in, word_valid, mem_ack,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/uart_program_loader.sv
// Loads a length/data/XOR-checksum frame of converted words into instruction memory,
// holding the CPU in reset while the load is in progress.
module uart_program_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MAX_WORDS  = 1024,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_req,
  uart_program_loader_if.master bus,
  output logic                  conv_rst,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0]           MaxWords = 32'(MAX_WORDS);
  localparam logic [1:0] ErrNone = 2'b00, ErrLen = 2'b01, ErrSum = 2'b10, ErrOvf = 2'b11;

  typedef enum logic [2:0] {
    StIdle, StClear, StWaitLen, StWaitData, StWrite, StWaitSum, StDone, StError
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [1:0]            err_q, err_d;
  logic [ADDR_WIDTH:0]   wl_q, wl_d;
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic [31:0]           sum_q, sum_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [31:0]           pend_q, pend_d;
  logic [ADDR_WIDTH:0]   wl_inc;
  logic [31:0]           sum_word;

  assign wl_inc   = wl_q + 1'b1;
  // A buffered word takes priority as the checksum candidate.
  assign sum_word = pend_vld_q ? pend_q : bus.word_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= BaseAddr;
      wdata_q    <= '0;
      err_q      <= ErrNone;
      wl_q       <= '0;
      n_q        <= '0;
      sum_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      wl_q       <= wl_d;
      n_q        <= n_d;
      sum_q      <= sum_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    wl_d       = wl_q;
    n_d        = n_q;
    sum_d      = sum_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (load_req) begin
          state_d = StClear;
          err_d   = ErrNone;
          wl_d    = '0;
          sum_d   = '0;
          n_d     = '0;
          addr_d  = BaseAddr;
        end
      end
      StClear: state_d = StWaitLen;
      StWaitLen: begin
        if (bus.word_valid) begin
          if (bus.word_in == 32'd0 || bus.word_in > MaxWords) begin
            state_d = StError;
            err_d   = ErrLen;
          end else begin
            n_d     = bus.word_in[ADDR_WIDTH:0];
            state_d = StWaitData;
          end
        end
      end
      StWaitData: begin
        if (bus.word_valid) begin
          state_d = StWrite;
          we_d    = 1'b1;
          wdata_d = bus.word_in;
          addr_d  = BaseAddr + wl_q[ADDR_WIDTH-1:0];
          sum_d   = sum_q ^ bus.word_in;
        end
      end
      StWrite: begin
        if (bus.mem_ack) begin
          wl_d = wl_inc;
          if (wl_inc == n_q) begin
            state_d = StWaitSum;
            we_d    = 1'b0;
            if (!pend_vld_q && bus.word_valid) begin
              pend_vld_d = 1'b1;
              pend_d     = bus.word_in;
            end
          end else if (pend_vld_q) begin
            wdata_d    = pend_q;
            addr_d     = BaseAddr + wl_inc[ADDR_WIDTH-1:0];
            sum_d      = sum_q ^ pend_q;
            pend_vld_d = bus.word_valid;
            pend_d     = bus.word_in;
          end else if (bus.word_valid) begin
            // Word arriving on the ack cycle launches straight into the next write.
            wdata_d = bus.word_in;
            addr_d  = BaseAddr + wl_inc[ADDR_WIDTH-1:0];
            sum_d   = sum_q ^ bus.word_in;
          end else begin
            state_d = StWaitData;
            we_d    = 1'b0;
          end
        end else if (bus.word_valid) begin
          if (pend_vld_q) begin
            state_d    = StError;
            err_d      = ErrOvf;
            we_d       = 1'b0;
            pend_vld_d = 1'b0;
          end else begin
            pend_vld_d = 1'b1;
            pend_d     = bus.word_in;
          end
        end
      end
      StWaitSum: begin
        if (pend_vld_q || bus.word_valid) begin
          pend_vld_d = 1'b0;
          if (sum_word == sum_q) begin
            state_d = StDone;
          end else begin
            state_d = StError;
            err_d   = ErrSum;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    conv_rst      = (state_q == StClear);
    busy          = (state_q == StClear) || (state_q == StWaitLen) ||
                    (state_q == StWaitData) || (state_q == StWrite) || (state_q == StWaitSum);
    cpu_rst_n     = !busy;
    done          = (state_q == StDone);
    error         = (state_q == StError);
    err_code      = err_q;
    words_loaded  = wl_q;
    bus.mem_we    = we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
  end

endmodule
